// File: rtl/window_fetch_if.sv
// Coordinate input, image-memory read port and pixel output stream of window_fetch.
interface window_fetch_if #(
  parameter int IMG_WIDTH  = 41,
  parameter int IMG_HEIGHT = 50,
  parameter int DATA_W     = 8
);
  localparam int W_X = $clog2(IMG_WIDTH);
  localparam int W_Y = $clog2(IMG_HEIGHT);
  localparam int W_A = $clog2(IMG_WIDTH*IMG_HEIGHT);

  logic              addr_valid;
  logic              addr_ready;
  logic [W_X-1:0]    x;
  logic [W_Y-1:0]    y;
  logic              mem_rd_en;
  logic [W_A-1:0]    mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              pixel_valid;
  logic              pixel_ready;
  logic [DATA_W-1:0] pixel_data;
  logic              pixel_last;
  logic              pixel_oob;

  modport slave (
    input  addr_valid, x, y, mem_rdata, pixel_ready,
    output addr_ready, mem_rd_en, mem_addr, pixel_valid, pixel_data, pixel_last, pixel_oob
  );

  modport master (
    output addr_valid, x, y, mem_rdata, pixel_ready,
    input  addr_ready, mem_rd_en, mem_addr, pixel_valid, pixel_data, pixel_last, pixel_oob
  );
endinterface

// File: rtl/window_fetch.sv
// Converts sweeper (x, y) coordinates to image-memory reads and buffers the
// returned pixels, tagged with end-of-window and out-of-bounds flags.
module window_fetch #(
  parameter int IMG_WIDTH  = 41,
  parameter int IMG_HEIGHT = 50,
  parameter int SWEEP_X    = 25,
  parameter int SWEEP_Y    = 25,
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 3
) (
  input  logic           clk,
  input  logic           rst,
  window_fetch_if.slave  bus
);
  localparam int W_X     = $clog2(IMG_WIDTH);
  localparam int W_Y     = $clog2(IMG_HEIGHT);
  localparam int W_A     = $clog2(IMG_WIDTH*IMG_HEIGHT);
  localparam int WIN_N   = SWEEP_X*SWEEP_Y;
  localparam int WIN_MAX = WIN_N - 1;
  localparam int W_C     = (WIN_N > 1) ? $clog2(WIN_N) : 1;
  localparam int W_P     = $clog2(FIFO_DEPTH);
  localparam int W_F     = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_MAX_I = FIFO_DEPTH - 1;

  localparam logic [W_X:0]   X_LIM   = IMG_WIDTH[W_X:0];
  localparam logic [W_Y:0]   Y_LIM   = IMG_HEIGHT[W_Y:0];
  localparam logic [W_A-1:0] PITCH   = IMG_WIDTH[W_A-1:0];
  localparam logic [W_C-1:0] CNT_MAX = WIN_MAX[W_C-1:0];
  localparam logic [W_P-1:0] PTR_MAX = PTR_MAX_I[W_P-1:0];
  localparam logic [W_F:0]   DEPTH_L = FIFO_DEPTH[W_F:0];

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              oob;
  } pix_t;

  function automatic logic [W_P-1:0] ptr_nxt(input logic [W_P-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  logic           oob, hs, push, pop;
  logic [W_F:0]   occ;
  logic [W_C-1:0] win_cnt;
  logic           inflight, inf_use_mem, inf_last, inf_oob;
  pix_t           fifo_mem [FIFO_DEPTH];
  pix_t           wr_ent, head;
  logic [W_P-1:0] wr_ptr, rd_ptr;
  logic [W_F-1:0] fifo_count;

  // Credit counts the in-flight read too, so a push can never find the FIFO full.
  assign occ            = {1'b0, fifo_count} + {{W_F{1'b0}}, inflight};
  assign bus.addr_ready = ~rst & (occ < DEPTH_L);

  assign oob          = ({1'b0, bus.x} >= X_LIM) | ({1'b0, bus.y} >= Y_LIM);
  assign hs           = bus.addr_valid & bus.addr_ready;
  assign bus.mem_addr = W_A'(bus.y) * PITCH + W_A'(bus.x);
  assign bus.mem_rd_en = hs & ~oob;

  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt     <= '0;
      inflight    <= 1'b0;
      inf_use_mem <= 1'b0;
      inf_last    <= 1'b0;
      inf_oob     <= 1'b0;
    end else begin
      inflight <= hs;
      if (hs) begin
        inf_use_mem <= ~oob;
        inf_last    <= (win_cnt == CNT_MAX);
        inf_oob     <= oob;
        win_cnt     <= (win_cnt == CNT_MAX) ? '0 : win_cnt + 1'b1;
      end
    end
  end

  // mem_rdata is only meaningful in the cycle after the read strobe.
  assign push   = inflight;
  assign pop    = bus.pixel_valid & bus.pixel_ready;
  assign wr_ent = '{data: inf_use_mem ? bus.mem_rdata : '0, last: inf_last, oob: inf_oob};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= wr_ent;
        wr_ptr           <= ptr_nxt(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_nxt(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head            = fifo_mem[rd_ptr];
  assign bus.pixel_valid = (fifo_count != '0);
  assign bus.pixel_data  = head.data;
  assign bus.pixel_last  = head.last;
  assign bus.pixel_oob   = head.oob;
endmodule

// File: tb/tb_window_fetch.sv
// Randomized bench for window_fetch with a queue-based reference model and 1-cycle BRAM model.
module tb_window_fetch;
  localparam int IMG_WIDTH  = 41;
  localparam int IMG_HEIGHT = 50;
  localparam int SWEEP_X    = 25;
  localparam int SWEEP_Y    = 25;
  localparam int DATA_W     = 8;
  localparam int FIFO_DEPTH = 3;
  localparam int WIN_N      = SWEEP_X*SWEEP_Y;
  localparam int W_X        = $clog2(IMG_WIDTH);
  localparam int W_Y        = $clog2(IMG_HEIGHT);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  window_fetch_if #(.IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .DATA_W(DATA_W)) bus ();

  window_fetch #(
    .IMG_WIDTH(IMG_WIDTH), .IMG_HEIGHT(IMG_HEIGHT), .SWEEP_X(SWEEP_X), .SWEEP_Y(SWEEP_Y),
    .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct {
    int data;
    bit last;
    bit oob;
    int t_avail;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0, n_pass = 0;
  int   cyc = 0, hs_cnt = 0, wcnt = 0, mode = 0;
  bit   hold_prev = 0;
  int   head_prev = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Image memory: memory[a] = a mod 256, junk on the bus when not reading.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= bus.mem_addr[7:0];
    else               bus.mem_rdata <= 8'($urandom);
  end

  initial begin
    bus.pixel_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0:       bus.pixel_ready = 1'b1;
        1:       bus.pixel_ready = 1'b0;
        default: bus.pixel_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  // Monitor and reference model, sampled mid-cycle.
  exp_t e;
  bit   m_valid, m_hs, m_oob;
  int   m_x, m_y;
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_addr_ready", int'(bus.addr_ready), 0);
      chk("rst_rd_en", int'(bus.mem_rd_en), 0);
      q.delete();
      wcnt      = 0;
      hold_prev = 0;
    end else begin
      m_valid = (q.size() > 0) && (q[0].t_avail <= cyc);
      chk("addr_ready", int'(bus.addr_ready), int'(q.size() < FIFO_DEPTH));
      chk("pixel_valid", int'(bus.pixel_valid), int'(m_valid));
      if (hold_prev)
        chk("head_stable", int'({bus.pixel_valid, bus.pixel_data, bus.pixel_last, bus.pixel_oob}), head_prev);
      chk("no_overflow", int'(dut.inflight && int'(dut.fifo_count) == FIFO_DEPTH), 0);
      m_x   = int'(bus.x);
      m_y   = int'(bus.y);
      m_oob = (m_x >= IMG_WIDTH) || (m_y >= IMG_HEIGHT);
      m_hs  = bus.addr_valid && bus.addr_ready;
      chk("mem_rd_en", int'(bus.mem_rd_en), int'(m_hs && !m_oob));
      if (m_hs && !m_oob) chk("mem_addr", int'(bus.mem_addr), m_y*IMG_WIDTH + m_x);
      if (m_valid && bus.pixel_ready) begin
        chk("pix_data", int'(bus.pixel_data), q[0].data);
        chk("pix_last", int'(bus.pixel_last), int'(q[0].last));
        chk("pix_oob", int'(bus.pixel_oob), int'(q[0].oob));
        void'(q.pop_front());
      end
      hold_prev = bus.pixel_valid && !bus.pixel_ready;
      head_prev = int'({1'b1, bus.pixel_data, bus.pixel_last, bus.pixel_oob});
      if (m_hs) begin
        e.data    = m_oob ? 0 : (m_y*IMG_WIDTH + m_x) % 256;
        e.last    = (wcnt == WIN_N - 1);
        e.oob     = m_oob;
        e.t_avail = cyc + 2;
        q.push_back(e);
        wcnt = (wcnt + 1) % WIN_N;
        hs_cnt++;
      end
    end
    cyc++;
    if (cyc > 90000) begin
      $display("FAIL watchdog: cycle %0d exceeds budget", cyc);
      $fatal(1, "watchdog expired");
    end
  end

  task automatic send(input int xv, input int yv, output int waited);
    waited = 0;
    bus.addr_valid = 1'b1;
    bus.x = W_X'(xv);
    bus.y = W_Y'(yv);
    @(negedge clk);
    while (!bus.addr_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.addr_ready) chk("hs_timeout", waited, 0);
    @(posedge clk); #1;
    bus.addr_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.addr_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    mode = 0;
    while (q.size() != 0 && w < 100) begin @(posedge clk); #1; w++; end
    chk("drain", q.size(), 0);
  endtask

  task automatic stream(input int n, input bit gap_chk);
    int w;
    for (int i = 0; i < n; i++) begin
      send($urandom_range(0, IMG_WIDTH-1), $urandom_range(0, IMG_HEIGHT-1), w);
      if (gap_chk) chk("stream_gap", w, 0);
    end
  endtask

  int w, base;
  initial begin
    rst = 1'b1;
    bus.addr_valid = 1'b0;
    bus.x = '0;
    bus.y = '0;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_pixel_valid", int'(bus.pixel_valid), 0);
    chk("rst_pixel_data", int'(bus.pixel_data), 0);
    chk("rst_pixel_last", int'(bus.pixel_last), 0);
    chk("rst_pixel_oob", int'(bus.pixel_oob), 0);
    rst = 1'b0;

    // Directed addresses 0, 1, 2049.
    send(0, 0, w);
    chk("first_gap", w, 0);
    send(1, 0, w);
    send(40, 49, w);
    drain();

    // One full window at full rate, plus the start of the next.
    pulse_rst();
    stream(WIN_N + 5, 1'b1);
    drain();

    // Backpressure from the start: only FIFO_DEPTH accepted.
    pulse_rst();
    mode = 1;
    idle(2);
    base = hs_cnt;
    fork
      stream(10, 1'b0);
      begin
        repeat (20) begin @(posedge clk); #1; end
        chk("bp_accepted", hs_cnt - base, FIFO_DEPTH);
        chk("bp_ready_low", int'(bus.addr_ready), 0);
        mode = 0;
      end
    join
    drain();
    chk("bp_all_out", hs_cnt - base, 10);

    // Out-of-bounds coordinates interleaved; last must still land on 625th.
    pulse_rst();
    send(41, 0, w);
    send(3, 2, w);
    send(0, 50, w);
    send(40, 49, w);
    send(63, 63, w);
    send(0, 49, w);
    stream(WIN_N - 6 + 3, 1'b1);
    drain();

    // Random valid / ready toggling.
    mode = 2;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
      send($urandom_range(0, 47), $urandom_range(0, 55), w);
    end
    drain();

    // Reset with two pixels buffered and one in flight.
    mode = 1;
    idle(2);
    stream(3, 1'b0);
    chk("pre_rst_buffered", int'(dut.fifo_count), 2);
    chk("pre_rst_inflight", int'(dut.inflight), 1);
    pulse_rst();
    chk("post_rst_valid", int'(bus.pixel_valid), 0);
    mode = 0;
    idle(1);
    stream(WIN_N + 2, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
